// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM encoding and melody-entry constants for audio_sequencer
package audio_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, FWAIT, LOAD, HOLD, GAP} state_t;
  localparam int REST_NOTE = 0;
  localparam int END_DUR = 0;
  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W = 4;
endpackage

// File: rtl/tempo_tick.sv
// tempo_tick: TICK_DIV prescaler; ports clk, rst, clr (restart at 0), tick (pulse on count TICK_DIV-1)
module tempo_tick #(
  parameter int TICK_DIV = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = !clr && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/audio_sequencer.sv
// audio_sequencer: walks a {note, dur} melody ROM, loads the audio counter per note and gates it with mute
// ports: play/stop/loop control in; mel_addr/mel_data melody ROM; freq_addr, counter_load, mute to the audio path; busy/done status
module audio_sequencer
  import audio_pkg::*;
#(
  parameter int TICK_DIV = 1250000,
  parameter int MEL_AW = 8,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W = DEF_DUR_W,
  parameter int GAP_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    play,
  input  logic                    stop,
  input  logic                    loop,
  output logic [MEL_AW-1:0]       mel_addr,
  input  logic [NOTE_W+DUR_W-1:0] mel_data,
  output logic [NOTE_W-1:0]       freq_addr,
  output logic                    counter_load,
  output logic                    mute,
  output logic                    busy,
  output logic                    done
);
  state_t state;
  logic [DUR_W-1:0] dcnt;
  logic [NOTE_W-1:0] m_note;
  logic [DUR_W-1:0] m_dur;
  logic tick, clr;
  assign m_note = mel_data[NOTE_W+DUR_W-1:DUR_W];
  assign m_dur = mel_data[DUR_W-1:0];
  // the prescaler only runs while a note, rest or gap is being timed
  assign clr = stop || !(state == HOLD || state == GAP);
  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mel_addr <= '0;
      freq_addr <= '0;
      counter_load <= 1'b0;
      mute <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      dcnt <= '0;
    end else begin
      counter_load <= 1'b0;
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        mute <= 1'b1;
        busy <= 1'b0;
        dcnt <= '0;
      end else
        case (state)
          IDLE:
            if (play && !stop) begin
              mel_addr <= '0;
              busy <= 1'b1;
              state <= FETCH;
            end
          FETCH: state <= DECODE;
          DECODE:
            if (m_dur == DUR_W'(END_DUR)) begin
              if (loop) begin
                mel_addr <= '0;
                state <= FETCH;
              end else begin
                done <= 1'b1;
                busy <= 1'b0;
                state <= IDLE;
              end
            end else begin
              dcnt <= m_dur;
              if (m_note == NOTE_W'(REST_NOTE)) state <= HOLD;
              else begin
                freq_addr <= m_note;
                state <= FWAIT;
              end
            end
          FWAIT: begin
            counter_load <= 1'b1;
            state <= LOAD;
          end
          LOAD: begin
            mute <= 1'b0;
            state <= HOLD;
          end
          HOLD:
            if (tick) begin
              dcnt <= dcnt - 1'b1;
              if (dcnt == DUR_W'(1)) begin
                mute <= 1'b1;
                if (GAP_TICKS > 0) begin
                  dcnt <= DUR_W'(GAP_TICKS);
                  state <= GAP;
                end else begin
                  mel_addr <= mel_addr + 1'b1;
                  state <= FETCH;
                end
              end
            end
          GAP:
            if (tick) begin
              dcnt <= dcnt - 1'b1;
              if (dcnt == DUR_W'(1)) begin
                mel_addr <= mel_addr + 1'b1;
                state <= FETCH;
              end
            end
          default: state <= IDLE;
        endcase
    end
endmodule
